usb_xact_engine: RTL and testbench

Parametrised USB host transaction engine. It sits between the read/write transaction layer and the bit-stuff/NRZI encoder and decoder pair, and runs complete IN and OUT transactions: token, data, handshake. Compared with the previous protocol block, it adds:
- a configurable payload size, retry limit and timeout;
- per-endpoint DATA0/DATA1 toggle tracking;
- STALL handling;
- a retry count reported on completion.

---
 rtl/usb_xact_engine_if.sv | 47 ++++
 rtl/usb_xact_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_usb_xact_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_xact_engine_if.sv
// Transaction-layer request/response and encoder/decoder packet signals of the
// USB host transaction engine. The engine connects through the slave modport.
interface usb_xact_engine_if #(
    parameter int DATA_BYTES = 8,
    parameter int MAX_RETRY  = 8
);
    localparam int PW = 8 * DATA_BYTES;
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic          xact_start;
    logic [1:0]    xact_type;
    logic [6:0]    xact_addr;
    logic [3:0]    xact_ep;
    logic [PW-1:0] wdata;
    logic          clr_toggle;
    logic          busy;
    logic          xact_done;
    logic          xact_ok;
    logic          xact_stall;
    logic [RW-1:0] xact_retries;
    logic [PW-1:0] rdata;
    logic          rdata_valid;
    logic          tx_valid;
    logic [7:0]    tx_pid;
    logic [6:0]    tx_addr;
    logic [3:0]    tx_ep;
    logic [PW-1:0] tx_payload;
    logic          tx_sent;
    logic          rx_valid;
    logic          rx_corrupt;
    logic [7:0]    rx_pid;
    logic [PW-1:0] rx_payload;

    modport slave (
        input  xact_start, xact_type, xact_addr, xact_ep, wdata, clr_toggle,
        input  tx_sent, rx_valid, rx_corrupt, rx_pid, rx_payload,
        output busy, xact_done, xact_ok, xact_stall, xact_retries, rdata, rdata_valid,
        output tx_valid, tx_pid, tx_addr, tx_ep, tx_payload
    );

    modport master (
        output xact_start, xact_type, xact_addr, xact_ep, wdata, clr_toggle,
        output tx_sent, rx_valid, rx_corrupt, rx_pid, rx_payload,
        input  busy, xact_done, xact_ok, xact_stall, xact_retries, rdata, rdata_valid,
        input  tx_valid, tx_pid, tx_addr, tx_ep, tx_payload
    );
endinterface

// File: rtl/usb_xact_engine.sv
// USB host transaction engine: runs IN/OUT token-data-handshake sequences with
// retries, timeout, STALL handling and per-endpoint DATA0/DATA1 toggles.
module usb_xact_engine #(
    parameter int DATA_BYTES  = 8,
    parameter int NUM_EP      = 16,
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input logic              clk,
    input logic              rst_b,
    usb_xact_engine_if.slave bus
);
    localparam int PW = 8 * DATA_BYTES;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_STALL = 8'h1E;

    typedef enum logic [2:0] {
        S_IDLE, S_TOKEN, S_TX_DATA, S_WAIT_HS, S_WAIT_DATA, S_TX_HS, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          is_out_q, is_out_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    ep_q, ep_d;
    logic [PW-1:0] wdata_q, wdata_d;
    logic          tog_q, tog_d;
    logic [RW-1:0] att_q, att_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          again_q, again_d;
    logic          res_ok_q, res_ok_d;
    logic          res_stall_q, res_stall_d;
    logic [NUM_EP-1:0] toggle_q, toggle_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          stall_q, stall_d;
    logic [RW-1:0] retries_q, retries_d;
    logic [PW-1:0] rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_pid_q, tx_pid_d;
    logic [6:0]    tx_addr_q, tx_addr_d;
    logic [3:0]    tx_ep_q, tx_ep_d;
    logic [PW-1:0] tx_payload_q, tx_payload_d;

    logic start_tog, retry, flip, rx_good, rx_is_data, tmo_hit, can_retry, sent;

    always_comb begin
        state_d      = state_q;
        is_out_d     = is_out_q;
        addr_d       = addr_q;
        ep_d         = ep_q;
        wdata_d      = wdata_q;
        tog_d        = tog_q;
        att_d        = att_q;
        tmo_d        = tmo_q;
        again_d      = again_q;
        res_ok_d     = res_ok_q;
        res_stall_d  = res_stall_q;
        toggle_d     = toggle_q;
        ok_d         = ok_q;
        stall_d      = stall_q;
        retries_d    = retries_q;
        rdata_d      = rdata_q;
        rdata_valid_d = 1'b0;
        tx_pid_d     = tx_pid_q;
        tx_addr_d    = tx_addr_q;
        tx_ep_d      = tx_ep_q;
        tx_payload_d = tx_payload_q;
        retry        = 1'b0;
        flip         = 1'b0;
        start_tog    = 1'b0;
        for (int i = 0; i < NUM_EP; i++)
            if (bus.xact_ep == 4'(i)) start_tog = toggle_q[i];

        rx_good    = bus.rx_valid && !bus.rx_corrupt;
        rx_is_data = (bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1);
        // The wait state has lasted TIMEOUT_CYC cycles once this edge is taken.
        tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC - 1));
        can_retry  = ({1'b0, att_q} + 1'b1) < (RW + 1)'(MAX_RETRY);
        sent       = bus.tx_sent && tx_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clr_toggle)
                    for (int i = 0; i < NUM_EP; i++)
                        if (bus.xact_ep == 4'(i)) toggle_d[i] = 1'b0;
                if (bus.xact_start && (bus.xact_type == 2'b01 || bus.xact_type == 2'b10)) begin
                    is_out_d    = (bus.xact_type == 2'b10);
                    addr_d      = bus.xact_addr;
                    ep_d        = bus.xact_ep;
                    wdata_d     = bus.wdata;
                    tog_d       = bus.clr_toggle ? 1'b0 : start_tog;
                    att_d       = '0;
                    again_d     = 1'b0;
                    res_ok_d    = 1'b0;
                    res_stall_d = 1'b0;
                    state_d     = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (sent) begin
                    state_d = is_out_q ? S_TX_DATA : S_WAIT_DATA;
                    tmo_d   = '0;
                end
            end
            S_TX_DATA: begin
                if (sent) begin
                    state_d = S_WAIT_HS;
                    tmo_d   = '0;
                end
            end
            S_WAIT_HS: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.rx_valid) begin
                    if (rx_good && bus.rx_pid == PID_ACK) begin
                        flip     = 1'b1;
                        res_ok_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (rx_good && bus.rx_pid == PID_STALL) begin
                        res_stall_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (tmo_hit) begin
                    retry = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.rx_valid) begin
                    if (rx_good && rx_is_data) begin
                        // Any good DATA is acknowledged; a duplicate then retries.
                        state_d = S_TX_HS;
                        if ((bus.rx_pid == PID_DATA1) == tog_q) begin
                            rdata_d       = bus.rx_payload;
                            rdata_valid_d = 1'b1;
                            flip          = 1'b1;
                            res_ok_d      = 1'b1;
                            again_d       = 1'b0;
                        end else if (can_retry) begin
                            att_d   = att_q + 1'b1;
                            again_d = 1'b1;
                        end else begin
                            att_d   = RW'(MAX_RETRY);
                            again_d = 1'b0;
                        end
                    end else if (rx_good && bus.rx_pid == PID_STALL) begin
                        res_stall_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (tmo_hit) begin
                    retry = 1'b1;
                end
            end
            S_TX_HS: begin
                if (sent) state_d = again_q ? S_TOKEN : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (retry) begin
            if (can_retry) begin
                att_d   = att_q + 1'b1;
                state_d = S_TOKEN;
            end else begin
                att_d   = RW'(MAX_RETRY);
                state_d = S_DONE;
            end
        end

        if (flip)
            for (int i = 0; i < NUM_EP; i++)
                if (ep_q == 4'(i)) toggle_d[i] = ~tog_q;

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        tx_valid_d = (state_d inside {S_TOKEN, S_TX_DATA, S_TX_HS});
        if (state_d == S_DONE) begin
            ok_d      = res_ok_d;
            stall_d   = res_stall_d;
            retries_d = att_d;
        end

        case (state_d)
            S_TOKEN: begin
                tx_pid_d  = is_out_d ? PID_OUT : PID_IN;
                tx_addr_d = addr_d;
                tx_ep_d   = ep_d;
            end
            S_TX_DATA: begin
                tx_pid_d     = tog_d ? PID_DATA1 : PID_DATA0;
                tx_payload_d = wdata_d;
            end
            S_TX_HS: tx_pid_d = PID_ACK;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= S_IDLE;
            is_out_q      <= 1'b0;
            addr_q        <= '0;
            ep_q          <= '0;
            wdata_q       <= '0;
            tog_q         <= 1'b0;
            att_q         <= '0;
            tmo_q         <= '0;
            again_q       <= 1'b0;
            res_ok_q      <= 1'b0;
            res_stall_q   <= 1'b0;
            toggle_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ok_q          <= 1'b0;
            stall_q       <= 1'b0;
            retries_q     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_pid_q      <= '0;
            tx_addr_q     <= '0;
            tx_ep_q       <= '0;
            tx_payload_q  <= '0;
        end else begin
            state_q       <= state_d;
            is_out_q      <= is_out_d;
            addr_q        <= addr_d;
            ep_q          <= ep_d;
            wdata_q       <= wdata_d;
            tog_q         <= tog_d;
            att_q         <= att_d;
            tmo_q         <= tmo_d;
            again_q       <= again_d;
            res_ok_q      <= res_ok_d;
            res_stall_q   <= res_stall_d;
            toggle_q      <= toggle_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ok_q          <= ok_d;
            stall_q       <= stall_d;
            retries_q     <= retries_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            tx_valid_q    <= tx_valid_d;
            tx_pid_q      <= tx_pid_d;
            tx_addr_q     <= tx_addr_d;
            tx_ep_q       <= tx_ep_d;
            tx_payload_q  <= tx_payload_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.xact_done    = done_q;
    assign bus.xact_ok      = ok_q;
    assign bus.xact_stall   = stall_q;
    assign bus.xact_retries = retries_q;
    assign bus.rdata        = rdata_q;
    assign bus.rdata_valid  = rdata_valid_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_pid       = tx_pid_q;
    assign bus.tx_addr      = tx_addr_q;
    assign bus.tx_ep        = tx_ep_q;
    assign bus.tx_payload   = tx_payload_q;
endmodule

// File: tb/tb_usb_xact_engine.sv
// Bench for usb_xact_engine: a per-transaction model predicts packets, results
// and toggles from the device responses; a monitor compares every cycle.
module tb_usb_xact_engine;
    localparam int DB = 8, NEP = 16, MR = 8, TO = 255;
    localparam int R_ACK = 0, R_NAK = 1, R_STALL = 2, R_NONE = 3, R_BAD = 4, R_D0 = 5, R_D1 = 6;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    usb_xact_engine_if #(.DATA_BYTES(DB), .MAX_RETRY(MR)) bus ();
    usb_xact_engine #(.DATA_BYTES(DB), .NUM_EP(NEP), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus)
    );

    typedef struct { logic [7:0] pid; logic [6:0] addr; logic [3:0] ep; logic [63:0] pl; } pkt_t;
    typedef struct { logic ok; logic stall; int retries; } res_t;

    pkt_t        exp_pkt[$];
    res_t        exp_res[$];
    logic [63:0] exp_rd[$];
    int          resp_q[$];
    logic [63:0] resp_pl[$];
    logic        m_tog[NEP];
    int          n_cmp = 0, n_bad = 0, done_cnt = 0, rd_cnt = 0, d0, rd0;
    logic [7:0]  last_data_pid = 8'h00;
    pkt_t        mp;
    res_t        mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic add_resp(input int r, input logic [63:0] pl);
        resp_q.push_back(r);
        resp_pl.push_back(pl);
    endtask

    // Monitor: packets on tx_sent, payload on rdata_valid, results on xact_done.
    always @(negedge clk) if (rst_b) begin
        if (bus.tx_valid && bus.tx_sent) begin
            chk("busy_with_tx", 64'(bus.busy), 64'd1);
            if (exp_pkt.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pkt_unexpected: got pid %0h, want none", bus.tx_pid);
            end else begin
                mp = exp_pkt.pop_front();
                chk("tx_pid", 64'(bus.tx_pid), 64'(mp.pid));
                if (mp.pid == 8'hE1 || mp.pid == 8'h69) begin
                    chk("tx_addr", 64'(bus.tx_addr), 64'(mp.addr));
                    chk("tx_ep", 64'(bus.tx_ep), 64'(mp.ep));
                end
                if (mp.pid == 8'hC3 || mp.pid == 8'h4B) begin
                    chk("tx_payload", bus.tx_payload, mp.pl);
                    last_data_pid = bus.tx_pid;
                end
            end
        end
        if (bus.rdata_valid) begin
            rd_cnt++;
            if (exp_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rdata_unexpected: got %0h, want no pulse", bus.rdata);
            end else chk("rdata", bus.rdata, exp_rd.pop_front());
        end
        if (bus.xact_done) begin
            done_cnt++;
            chk("busy_with_done", 64'(bus.busy), 64'd1);
            if (exp_res.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_unexpected: got done, want none");
            end else begin
                mr = exp_res.pop_front();
                chk("xact_ok", 64'(bus.xact_ok), 64'(mr.ok));
                chk("xact_stall", 64'(bus.xact_stall), 64'(mr.stall));
                chk("xact_retries", 64'(bus.xact_retries), 64'(mr.retries));
            end
        end
    end

    task automatic send_pkt();
        int n = 0;
        while (!bus.tx_valid && n < 400) begin tick(); n++; end
        if (!bus.tx_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_valid_wait: got no packet request, want one within 400 cycles");
        end else begin
            tick();
            bus.tx_sent = 1'b1;
            tick();
            bus.tx_sent = 1'b0;
        end
    endtask

    task automatic respond(input int r, input logic [63:0] pl, input bit is_out, input bit tog);
        int n = 0;
        if (r == R_NONE) begin
            while (!bus.tx_valid && !bus.xact_done && n < 1000) begin tick(); n++; end
            chk("timeout_gap", 64'(n), 64'(TO));
        end else begin
            tick(); tick();
            bus.rx_valid   = 1'b1;
            bus.rx_corrupt = (r == R_BAD);
            bus.rx_payload = pl;
            case (r)
                R_ACK:   bus.rx_pid = 8'hD2;
                R_NAK:   bus.rx_pid = 8'h5A;
                R_STALL: bus.rx_pid = 8'h1E;
                R_D0:    bus.rx_pid = 8'hC3;
                R_D1:    bus.rx_pid = 8'h4B;
                default: bus.rx_pid = is_out ? 8'hD2 : (tog ? 8'h4B : 8'hC3);
            endcase
            tick();
            bus.rx_valid   = 1'b0;
            bus.rx_corrupt = 1'b0;
        end
    endtask

    // Model: each attempt is token (+data for OUT), then the scripted response.
    task automatic run_xact(input bit is_out, input logic [6:0] addr, input logic [3:0] ep,
                            input logic [63:0] wd, input bit clr);
        bit tog, fin = 0, ok = 0, stall = 0;
        int fails = 0, r, dc = done_cnt, n = 0;
        logic [63:0] pl;
        pkt_t tk, dp;
        if (clr) m_tog[ep] = 1'b0;
        tog = m_tog[ep];
        tk = '{is_out ? 8'hE1 : 8'h69, addr, ep, 64'h0};
        dp = '{tog ? 8'h4B : 8'hC3, 7'h0, 4'h0, wd};
        bus.xact_start = 1'b1;
        bus.xact_type  = is_out ? 2'b10 : 2'b01;
        bus.xact_addr  = addr;
        bus.xact_ep    = ep;
        bus.wdata      = wd;
        bus.clr_toggle = clr;
        tick();
        bus.xact_start = 1'b0;
        bus.clr_toggle = 1'b0;
        chk("start_to_token", 64'({bus.busy, bus.tx_valid}), 64'd3);
        while (!fin) begin
            r  = (resp_q.size() != 0) ? resp_q.pop_front() : R_NONE;
            pl = (resp_pl.size() != 0) ? resp_pl.pop_front() : 64'h0;
            exp_pkt.push_back(tk);
            send_pkt();
            if (is_out) begin exp_pkt.push_back(dp); send_pkt(); end
            respond(r, pl, is_out, tog);
            if (r == R_STALL) begin
                stall = 1; fin = 1;
            end else if (is_out && r == R_ACK) begin
                ok = 1; fin = 1; m_tog[ep] = !tog;
            end else if (!is_out && (r == R_D0 || r == R_D1)) begin
                exp_pkt.push_back('{8'hD2, 7'h0, 4'h0, 64'h0});
                if ((r == R_D1) == tog) begin
                    exp_rd.push_back(pl); ok = 1; fin = 1; m_tog[ep] = !tog;
                end else fails++;
                send_pkt();
            end else fails++;
            if (fails == MR) fin = 1;
        end
        exp_res.push_back('{ok, stall, fails});
        while (done_cnt == dc && n < 50) begin tick(); n++; end
        if (done_cnt == dc) begin
            n_cmp++; n_bad++;
            $display("FAIL done_wait: got no xact_done, want one within 50 cycles");
        end
        chk("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl", 64'({bus.busy, bus.xact_done, bus.xact_ok, bus.xact_stall,
                             bus.rdata_valid, bus.tx_valid, bus.xact_retries}), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_tx", 64'({bus.tx_pid, bus.tx_addr, bus.tx_ep}), 64'd0);
        chk("rst_tx_payload", bus.tx_payload, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.xact_start = 0; bus.xact_type = 0; bus.xact_addr = 0; bus.xact_ep = 0;
        bus.wdata = 0; bus.clr_toggle = 0; bus.tx_sent = 0; bus.rx_valid = 0;
        bus.rx_corrupt = 0; bus.rx_pid = 0; bus.rx_payload = 0;
        for (int i = 0; i < NEP; i++) m_tog[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_b = 1'b1;
        tick();

        // OUT ep3 ACKed: DATA0 first, DATA1 on the next OUT
        add_resp(R_ACK, 0);
        run_xact(1, 7'h12, 4'd3, 64'h1111_2222_3333_4444, 0);
        chk("t1_data_pid", 64'(last_data_pid), 64'hC3);
        chk("t1_result", 64'({bus.xact_ok, bus.xact_stall, bus.xact_retries}), 64'({1'b1, 1'b0, 4'd0}));
        add_resp(R_ACK, 0);
        run_xact(1, 7'h12, 4'd3, 64'h5555_6666_7777_8888, 0);
        chk("t2_data_pid", 64'(last_data_pid), 64'h4B);

        // NAK, NAK, ACK
        add_resp(R_NAK, 0); add_resp(R_NAK, 0); add_resp(R_ACK, 0);
        run_xact(1, 7'h2A, 4'd5, 64'hA5A5_0F0F_F0F0_5A5A, 0);
        chk("t3_result", 64'({bus.xact_ok, bus.xact_retries}), 64'({1'b1, 4'd2}));

        // IN with a silent device: every attempt times out
        rd0 = rd_cnt;
        run_xact(0, 7'h33, 4'd1, 64'h0, 0);
        chk("t4_result", 64'({bus.xact_ok, bus.xact_stall, bus.xact_retries}), 64'({1'b0, 1'b0, 4'd8}));
        chk("t4_no_rdata", 64'(rd_cnt), 64'(rd0));

        // IN: duplicate DATA1, then the expected DATA0
        rd0 = rd_cnt;
        add_resp(R_D1, 64'hDEAD_BEEF_DEAD_BEEF);
        add_resp(R_D0, 64'h0123_4567_89AB_CDEF);
        run_xact(0, 7'h44, 4'd2, 64'h0, 0);
        chk("t5_rdata", bus.rdata, 64'h0123_4567_89AB_CDEF);
        chk("t5_one_pulse", 64'(rd_cnt - rd0), 64'd1);
        chk("t5_result", 64'({bus.xact_ok, bus.xact_retries}), 64'({1'b1, 4'd1}));

        // STALL on OUT, then the same endpoint still uses DATA0
        add_resp(R_STALL, 0);
        run_xact(1, 7'h05, 4'd6, 64'hCAFE_F00D_0000_0001, 0);
        chk("t6_result", 64'({bus.xact_ok, bus.xact_stall, bus.xact_retries}), 64'({1'b0, 1'b1, 4'd0}));
        add_resp(R_ACK, 0);
        run_xact(1, 7'h05, 4'd6, 64'hCAFE_F00D_0000_0002, 0);
        chk("t6_toggle_kept", 64'(last_data_pid), 64'hC3);

        // IN: corrupt DATA ignored, then STALL
        add_resp(R_BAD, 64'h1234); add_resp(R_STALL, 0);
        run_xact(0, 7'h06, 4'd7, 64'h0, 0);
        chk("t7_result", 64'({bus.xact_stall, bus.xact_retries}), 64'({1'b1, 4'd1}));

        // clr_toggle with start on ep5 (toggle 1), corrupt ACK then ACK
        add_resp(R_BAD, 0); add_resp(R_ACK, 0);
        run_xact(1, 7'h2A, 4'd5, 64'h0BAD_C0DE_0BAD_C0DE, 1);
        chk("t8_clr_pid", 64'(last_data_pid), 64'hC3);

        // Invalid types are no-ops
        d0 = done_cnt;
        bus.xact_start = 1'b1; bus.xact_type = 2'b00; tick();
        bus.xact_type = 2'b11; tick();
        bus.xact_start = 1'b0; tick(); tick();
        chk("t9_idle", 64'({bus.busy, bus.tx_valid}), 64'd0);
        chk("t9_no_done", 64'(done_cnt), 64'(d0));

        // Reset in WAIT_HS with ep3 toggle at 1
        add_resp(R_ACK, 0);
        run_xact(1, 7'h12, 4'd3, 64'h9999_0000_9999_0000, 0);
        d0 = done_cnt;
        bus.xact_start = 1'b1; bus.xact_type = 2'b10; bus.xact_addr = 7'h12;
        bus.xact_ep = 4'd3; bus.wdata = 64'h7777_7777_7777_7777;
        tick();
        bus.xact_start = 1'b0;
        exp_pkt.push_back('{8'hE1, 7'h12, 4'd3, 64'h0});
        send_pkt();
        exp_pkt.push_back('{8'h4B, 7'h0, 4'h0, 64'h7777_7777_7777_7777});
        send_pkt();
        tick(); tick();
        rst_b = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        rst_b = 1'b1;
        for (int i = 0; i < NEP; i++) m_tog[i] = 1'b0;
        repeat (5) tick();
        chk("t10_no_done", 64'(done_cnt), 64'(d0));
        add_resp(R_ACK, 0);
        run_xact(1, 7'h12, 4'd3, 64'h1357_9BDF_2468_ACE0, 0);
        chk("t10_data0", 64'(last_data_pid), 64'hC3);

        chk("exp_drained", 64'(exp_pkt.size() + exp_res.size() + exp_rd.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
